alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_W, default 16, width of per-requester grant counters.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
REQ-004 SHALL have requester ports, n = 0,1:
  reqn_valid  input  1  request present
  reqn_a  input  DATA_W  operand a
  reqn_b  input  DATA_W  operand b
  reqn_ctrl  input  4  ALU function select
  reqn_ready  output  1  request accepted this cycle
REQ-005 SHALL have shared-ALU ports:
  alu_a  output  DATA_W  ALU src1
  alu_b  output  DATA_W  ALU src2
  alu_control  output  4  ALU function select
  alu_result  input  DATA_W  combinational ALU result
REQ-006 SHALL have response and status ports:
  rsp_valid  output  1  result held
  rsp_id  output  1  requester owning result
  rsp_result  output  DATA_W  registered result
  rsp_ready  input  1  consumer takes result
  grant_cnt0  output  CNT_W  completed grants, requester 0
  grant_cnt1  output  CNT_W  completed grants, requester 1

Function
REQ-007 SHALL implement two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-008 SHALL define slot_free = (state==EMPTY) or rsp_ready.
REQ-009 SHALL grant at most one requester per cycle, only when slot_free and that reqn_valid=1.
REQ-010 SHALL arbitrate round-robin: both valid -> grant requester not granted last; one valid -> grant it.
REQ-011 SHALL update the last-grant pointer only on a grant.
REQ-012 SHALL drive reqn_ready=1 combinationally only for the granted requester; all others 0.
REQ-013 SHALL drive alu_a/alu_b/alu_control from the granted request combinationally in the grant cycle; zeros when no grant.
REQ-014 SHALL on grant, at next rising edge, load rsp_result<=alu_result, rsp_id<=granted index, state<=FULL (latency 1 cycle).
REQ-015 SHALL in FULL with rsp_ready=1 and no grant go to EMPTY; with grant, stay FULL with new result (throughput 1/cycle).
REQ-016 SHALL in FULL with rsp_ready=0 hold rsp_valid, rsp_id, rsp_result unchanged and drive both reqn_ready=0.
REQ-017 SHALL not depend on reqn_ready inside requesters; requesters hold valid and operands stable until ready (no combinational loop).
REQ-018 SHALL pass alu_result unmodified; no width change, no interpretation of ctrl codes.
REQ-019 SHALL increment grant_cntn by 1 per grant to requester n, saturating at all-ones.

Reset
REQ-020 SHALL on rst_n=0, asynchronously: state=EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, grant_cnt0=grant_cnt1=0, last-grant pointer=1 (requester 0 wins first contention).
REQ-021 SHALL discard any held result on reset mid-operation; reqn_ready=0 while rst_n=0.

Verification
REQ-022 SHALL pass: req0 a=5 b=7 ctrl=0000, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, grant_cnt0=1.
REQ-023 SHALL pass: both valid continuously from reset, rsp_ready=1 -> grant order 0,1,0,1; rsp_id follows one cycle later.
REQ-024 SHALL pass: FULL, rsp_ready=0, req1 a=3 b=5 ctrl=1000 -> req1_ready=0, rsp held; raise rsp_ready -> req1_ready=1 that cycle, next rsp_result=0xFFFFFFFE, rsp_id=1.
REQ-025 SHALL pass: req0 a=0x80000000 b=4 ctrl=1101 -> rsp_result=0xF8000000.
REQ-026 SHALL pass: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately, counters 0; after release both valid -> req0 granted first.
REQ-027 SHALL pass: 65536 grants to req0 with CNT_W=16 -> grant_cnt0 stops at 0xFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; result registered 1 cycle after grant.
// Single-entry response slot: grants only when slot empty or being drained, so consumer stall blocks both requesters.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              req1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_id;
    logic [DATA_W-1:0]   r_result;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;

    logic                w_slot_free;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt;

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign w_slot_free = rst_n && ((r_state == EMPTY) || rsp_ready);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_slot_free) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_gnt      = w_gnt0 || w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = 4'b0000;
        if (w_gnt0) begin
            alu_a       = req0_a;
            alu_b       = req0_b;
            alu_control = req0_ctrl;
        end else if (w_gnt1) begin
            alu_a       = req1_a;
            alu_b       = req1_b;
            alu_control = req1_ctrl;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt) begin
            w_state_nxt = FULL;
        end else if (rsp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt) begin
                r_last   <= w_gnt1;
                r_id     <= w_gnt1;
                r_result <= alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_ONE;
            if (w_gnt1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + CNT_ONE;
        end
    end

    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule
